// File: rtl/ddr_wr_arbiter_if.sv
// ddr_wr_arbiter_if: requester-side and M00 AXI4 write-path signals of the write arbiter
interface ddr_wr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [2*ADDR_W-1:0]   s_awaddr;
    logic [15:0]           s_awlen;
    logic [1:0]            s_awvalid;
    logic [1:0]            s_awready;
    logic [2*DATA_W-1:0]   s_wdata;
    logic [2*DATA_W/8-1:0] s_wstrb;
    logic [1:0]            s_wlast;
    logic [1:0]            s_wvalid;
    logic [1:0]            s_wready;
    logic [1:0]            s_bresp;
    logic [1:0]            s_bvalid;
    logic [1:0]            s_bready;
    logic [ID_W-1:0]       M_AXI_AWID;
    logic [ADDR_W-1:0]     M_AXI_AWADDR;
    logic [7:0]            M_AXI_AWLEN;
    logic [2:0]            M_AXI_AWSIZE;
    logic [1:0]            M_AXI_AWBURST;
    logic                  M_AXI_AWLOCK;
    logic [3:0]            M_AXI_AWCACHE;
    logic [2:0]            M_AXI_AWPROT;
    logic [3:0]            M_AXI_AWQOS;
    logic                  M_AXI_AWVALID;
    logic                  M_AXI_AWREADY;
    logic [DATA_W-1:0]     M_AXI_WDATA;
    logic [DATA_W/8-1:0]   M_AXI_WSTRB;
    logic                  M_AXI_WLAST;
    logic                  M_AXI_WVALID;
    logic                  M_AXI_WREADY;
    logic [ID_W-1:0]       M_AXI_BID;
    logic [1:0]            M_AXI_BRESP;
    logic                  M_AXI_BVALID;
    logic                  M_AXI_BREADY;

    // slave: the arbiter itself (slave to the requesters, driving the interconnect)
    modport slave (
        input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID
    );

    // master: the requesters plus the interconnect seen from outside the arbiter
    modport master (
        output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
               M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
               M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin, one-burst-outstanding sharing of the M00 AXI4 write path
module ddr_wr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              areset,
    ddr_wr_arbiter_if.slave   bus,
    output logic [1:0]        grant,
    output logic              len_err,
    output logic              timeout_err,
    output logic [15:0]       burst_cnt
);
    localparam int SW = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t        state, state_nxt;
    logic          g, last, win, req_any, aw_hs, w_hs, b_hs, tmo;
    logic [7:0]    len;
    logic [8:0]    beat;
    logic [TW-1:0] timer;

    function automatic logic [1:0] route(input logic v, input logic sel);
        return sel ? {v, 1'b0} : {1'b0, v};
    endfunction

    assign bus.M_AXI_AWSIZE  = 3'($clog2(SW));
    assign bus.M_AXI_AWBURST = 2'b01;
    assign bus.M_AXI_AWLOCK  = 1'b0;
    assign bus.M_AXI_AWCACHE = 4'b0011;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWQOS   = 4'b0000;
    assign bus.M_AXI_AWID    = ID_W'(g);
    assign bus.M_AXI_AWADDR  = g ? bus.s_awaddr[2*ADDR_W-1:ADDR_W] : bus.s_awaddr[ADDR_W-1:0];
    assign bus.M_AXI_AWLEN   = g ? bus.s_awlen[15:8] : bus.s_awlen[7:0];
    assign bus.M_AXI_WDATA   = g ? bus.s_wdata[2*DATA_W-1:DATA_W] : bus.s_wdata[DATA_W-1:0];
    assign bus.M_AXI_WSTRB   = g ? bus.s_wstrb[2*SW-1:SW] : bus.s_wstrb[SW-1:0];
    assign bus.M_AXI_WLAST   = bus.s_wlast[g];
    assign bus.s_bresp       = bus.M_AXI_BRESP;

    always_comb begin
        req_any = |bus.s_awvalid;
        win = bus.s_awvalid[~last] ? ~last : last;
        aw_hs = state == AW && bus.s_awvalid[g] && bus.M_AXI_AWREADY;
        w_hs = state == W && bus.s_wvalid[g] && bus.M_AXI_WREADY;
        b_hs = state == B && bus.s_bready[g] && bus.M_AXI_BVALID;
        // a completing handshake always beats an expiring timer
        tmo = (state == W || state == B) && !w_hs && !b_hs && timer == TLAST;
        bus.M_AXI_AWVALID = state == AW && bus.s_awvalid[g];
        bus.M_AXI_WVALID = state == W && bus.s_wvalid[g];
        bus.M_AXI_BREADY = state == B && bus.s_bready[g];
        bus.s_awready = state == AW ? route(bus.M_AXI_AWREADY, g) : 2'b00;
        bus.s_wready = state == W ? route(bus.M_AXI_WREADY, g) : 2'b00;
        bus.s_bvalid = state == B ? route(bus.M_AXI_BVALID, g) : 2'b00;
        state_nxt = tmo ? IDLE :
                    (state == IDLE && req_any) ? AW :
                    aw_hs ? W :
                    (w_hs && bus.M_AXI_WLAST) ? B :
                    b_hs ? IDLE : state;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            g           <= 1'b0;
            last        <= 1'b1;
            grant       <= 2'b00;
            len         <= 8'd0;
            beat        <= 9'd0;
            timer       <= '0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            burst_cnt   <= 16'd0;
        end else begin
            if (state == IDLE && req_any) begin
                g     <= win;
                grant <= route(1'b1, win);
            end
            if (aw_hs) begin
                len   <= bus.M_AXI_AWLEN;
                beat  <= 9'd0;
                timer <= '0;
            end
            if (w_hs) begin
                beat  <= beat + 1'b1;
                timer <= '0;
                if (bus.M_AXI_WLAST && beat != {1'b0, len})
                    len_err <= 1'b1;
            end else if (state == W || state == B) begin
                timer <= timer + 1'b1;
            end
            if (b_hs) begin
                burst_cnt <= burst_cnt + 1'b1;
                last      <= g;
                grant     <= 2'b00;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
                last        <= g;
                grant       <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: directed vector table of whole bursts plus hand-written reset and timeout sequences
module tb_ddr_wr_arbiter;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  grant;
    logic        len_err, timeout_err;
    logic [15:0] burst_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    ddr_wr_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    ddr_wr_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .areset(areset), .bus(bus), .grant(grant),
        .len_err(len_err), .timeout_err(timeout_err), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pre_rst;
        logic [1:0]  req;
        logic        w;
        logic [7:0]  len;
        int          beats;
        logic [1:0]  resp;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t v [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.s_awaddr = {32'h0000_2000, 32'h0000_1000};
        bus.s_awlen = 16'h0;
        bus.s_awvalid = 2'b00;
        bus.s_wdata = 64'h0;
        bus.s_wstrb = 8'h0;
        bus.s_wlast = 2'b00;
        bus.s_wvalid = 2'b00;
        bus.s_bready = 2'b00;
        bus.M_AXI_AWREADY = 1'b0;
        bus.M_AXI_WREADY = 1'b0;
        bus.M_AXI_BID = 4'h0;
        bus.M_AXI_BRESP = 2'b00;
        bus.M_AXI_BVALID = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle();
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cnt", 32'(burst_cnt), 0);
        chk("rst_len_err", 32'(len_err), 0);
        chk("rst_tmo_err", 32'(timeout_err), 0);
        chk("rst_awvalid", 32'(bus.M_AXI_AWVALID), 0);
        chk("rst_wvalid", 32'(bus.M_AXI_WVALID), 0);
        chk("rst_bready", 32'(bus.M_AXI_BREADY), 0);
        chk("rst_awid", 32'(bus.M_AXI_AWID), 0);
        tick();
        areset = 1'b0;
    endtask

    task automatic burst(input logic [1:0] req, input logic w, input logic [7:0] len,
                         input int beats, input logic [1:0] resp);
        logic [1:0]  wm;
        logic [31:0] own, other;
        wm = w ? 2'b10 : 2'b01;
        bus.s_awaddr = {32'h0000_2000, 32'h0000_1000};
        bus.s_awlen = {len, len};
        bus.s_awvalid = req;
        #1 chk("aw_latency", 32'(bus.M_AXI_AWVALID), 0);
        tick();
        chk("grant", 32'(grant), 32'(wm));
        chk("awvalid", 32'(bus.M_AXI_AWVALID), 1);
        chk("awid", 32'(bus.M_AXI_AWID), 32'(w));
        chk("awaddr", bus.M_AXI_AWADDR, w ? 32'h2000 : 32'h1000);
        chk("awlen", 32'(bus.M_AXI_AWLEN), 32'(len));
        bus.M_AXI_AWREADY = 1'b1;
        #1 chk("awready", 32'(bus.s_awready), 32'(wm));
        tick();
        bus.M_AXI_AWREADY = 1'b0;
        bus.s_awvalid = req & ~wm;
        bus.M_AXI_WREADY = 1'b1;
        for (int i = 0; i < beats; i++) begin
            own = 32'hA000_0000 | (32'(w) << 16) | 32'(i);
            other = 32'hDEAD_0000 | 32'(i);
            bus.s_wdata = w ? {own, other} : {other, own};
            bus.s_wstrb = 8'h3F;
            bus.s_wvalid = 2'b11;
            bus.s_wlast = (i == beats - 1) ? 2'b11 : 2'b00;
            #1;
            chk("wvalid", 32'(bus.M_AXI_WVALID), 1);
            chk("wdata", bus.M_AXI_WDATA, own);
            chk("wstrb", 32'(bus.M_AXI_WSTRB), w ? 32'h3 : 32'hF);
            chk("wlast", 32'(bus.M_AXI_WLAST), (i == beats - 1) ? 32'd1 : 32'd0);
            chk("wready", 32'(bus.s_wready), 32'(wm));
            chk("no_aw_in_w", 32'(bus.M_AXI_AWVALID), 0);
            tick();
        end
        bus.s_wvalid = 2'b00;
        bus.s_wlast = 2'b00;
        bus.M_AXI_WREADY = 1'b0;
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP = resp;
        bus.M_AXI_BID = 4'hF;
        bus.s_bready = 2'b11;
        #1;
        chk("bvalid", 32'(bus.s_bvalid), 32'(wm));
        chk("bresp", 32'(bus.s_bresp), 32'(resp));
        chk("bready", 32'(bus.M_AXI_BREADY), 1);
        tick();
        bus.M_AXI_BVALID = 1'b0;
        bus.s_bready = 2'b00;
        chk("grant_after_b", 32'(grant), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0] = '{1'b1, 2'b01, 1'b0, 8'd3, 4, 2'b00, 1'b0, 16'd1};
        v[1] = '{1'b1, 2'b11, 1'b0, 8'd3, 4, 2'b00, 1'b0, 16'd1};
        v[2] = '{1'b0, 2'b11, 1'b1, 8'd1, 2, 2'b01, 1'b0, 16'd2};
        v[3] = '{1'b0, 2'b11, 1'b0, 8'd0, 1, 2'b10, 1'b0, 16'd3};
        v[4] = '{1'b0, 2'b11, 1'b1, 8'd2, 3, 2'b00, 1'b0, 16'd4};
        v[5] = '{1'b0, 2'b10, 1'b1, 8'd3, 4, 2'b00, 1'b0, 16'd5};
        v[6] = '{1'b0, 2'b01, 1'b0, 8'd7, 5, 2'b00, 1'b1, 16'd6};
        v[7] = '{1'b0, 2'b10, 1'b1, 8'd0, 1, 2'b11, 1'b1, 16'd7};
        idle();
        do_reset();
        chk("awsize", 32'(bus.M_AXI_AWSIZE), 2);
        chk("awburst", 32'(bus.M_AXI_AWBURST), 1);
        chk("awlock", 32'(bus.M_AXI_AWLOCK), 0);
        chk("awcache", 32'(bus.M_AXI_AWCACHE), 3);
        chk("awprot", 32'(bus.M_AXI_AWPROT), 0);
        chk("awqos", 32'(bus.M_AXI_AWQOS), 0);

        for (int i = 0; i < 8; i++) begin
            if (v[i].pre_rst)
                do_reset();
            burst(v[i].req, v[i].w, v[i].len, v[i].beats, v[i].resp);
            chk("len_err", 32'(len_err), 32'(v[i].err));
            chk("burst_cnt", 32'(burst_cnt), 32'(v[i].cnt));
            chk("tmo_err_clear", 32'(timeout_err), 0);
        end

        // asynchronous reset during beat 2 of a requester-1 burst
        bus.s_awvalid = 2'b10;
        tick();
        chk("mr_grant", 32'(grant), 2);
        bus.M_AXI_AWREADY = 1'b1;
        tick();
        bus.M_AXI_AWREADY = 1'b0;
        bus.s_awvalid = 2'b00;
        bus.M_AXI_WREADY = 1'b1;
        bus.s_wvalid = 2'b10;
        bus.s_wdata = {32'h1111_0000, 32'h0};
        tick();
        tick();
        chk("mr_beat2_wvalid", 32'(bus.M_AXI_WVALID), 1);
        areset = 1'b1;
        #1;
        chk("mr_grant_rst", 32'(grant), 0);
        chk("mr_wvalid_rst", 32'(bus.M_AXI_WVALID), 0);
        chk("mr_wready_rst", 32'(bus.s_wready), 0);
        chk("mr_cnt_rst", 32'(burst_cnt), 0);
        chk("mr_len_err_rst", 32'(len_err), 0);
        tick();
        areset = 1'b0;
        idle();
        bus.s_awvalid = 2'b11;
        tick();
        chk("mr_fresh_grant", 32'(grant), 1);
        chk("mr_fresh_awid", 32'(bus.M_AXI_AWID), 0);

        // W phase stalled by the interconnect until the timer expires
        do_reset();
        bus.s_awvalid = 2'b01;
        tick();
        chk("to_grant", 32'(grant), 1);
        bus.M_AXI_AWREADY = 1'b1;
        tick();
        bus.M_AXI_AWREADY = 1'b0;
        bus.s_awvalid = 2'b10;
        bus.s_wvalid = 2'b01;
        repeat (15) tick();
        chk("to_before", 32'(timeout_err), 0);
        chk("to_grant_held", 32'(grant), 1);
        tick();
        chk("to_err", 32'(timeout_err), 1);
        chk("to_grant_drop", 32'(grant), 0);
        chk("to_wvalid_drop", 32'(bus.M_AXI_WVALID), 0);
        tick();
        chk("to_next_grant", 32'(grant), 2);
        chk("to_next_awid", 32'(bus.M_AXI_AWID), 1);
        chk("to_next_awvalid", 32'(bus.M_AXI_AWVALID), 1);
        chk("to_err_sticky", 32'(timeout_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
